// File: rtl/ahb_lite_rif_bridge.sv
// ---------------------------------------------------------------------------
// ahb_lite_rif_bridge
//
// Purpose:
//   AHB-Lite subordinate that converts bus transfers into single accesses on
//   a simple register interface (RIF). Each accepted transfer is checked up
//   front for size, alignment and security. A failing transfer receives a
//   two-cycle AHB ERROR response and is never forwarded to the RIF.
//   A passing transfer drives rif_req until the register file answers with
//   rif_ready, optionally with rif_err. A watchdog aborts the access with an
//   ERROR response if the register file never answers.
//   HREADYOUT, HRESP and rif_req are decoded from the state register alone,
//   so they never depend combinationally on bus inputs.
//
// Parameters:
//   ADDR_WIDTH      HADDR / rif_addr width
//   DATA_WIDTH      data width, a power of two from 8 to 1024
//   SEC_TRANS       1: transfers with HNONSEC=1 are rejected with ERROR
//   TIMEOUT_CYCLES  ACCESS cycles allowed before the watchdog fires (0 = off)
//   BYTE_COUNT      byte lanes, derived from DATA_WIDTH
//
// Ports:
//   HCLK, HRESET          clock, synchronous active-high reset
//   HSEL .. HREADY        AHB-Lite address/control/write-data inputs
//   HREADYOUT, HRESP      AHB-Lite response (state decoded)
//   HRDATA                registered read data
//   rif_req .. rif_wdata  RIF request, address, lane strobes, masked data
//   rif_ready, rif_err    RIF completion and error (error qualified by ready)
//   rif_rdata             RIF read data, valid with rif_ready
// ---------------------------------------------------------------------------
module ahb_lite_rif_bridge #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int SEC_TRANS      = 0,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int BYTE_COUNT     = DATA_WIDTH / 8
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic                  HNONSEC,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  rif_req,
    output logic                  rif_write,
    output logic [ADDR_WIDTH-1:0] rif_addr,
    output logic [BYTE_COUNT-1:0] rif_wstrb,
    output logic [DATA_WIDTH-1:0] rif_wdata,
    input  logic                  rif_ready,
    input  logic                  rif_err,
    input  logic [DATA_WIDTH-1:0] rif_rdata
);

    if (!(DATA_WIDTH == 8   || DATA_WIDTH == 16  || DATA_WIDTH == 32  ||
          DATA_WIDTH == 64  || DATA_WIDTH == 128 || DATA_WIDTH == 256 ||
          DATA_WIDTH == 512 || DATA_WIDTH == 1024)) begin : g_bad_width
        $fatal(1, "ahb_lite_rif_bridge: illegal DATA_WIDTH %0d", DATA_WIDTH);
    end

    if (BYTE_COUNT != DATA_WIDTH / 8) begin : g_bad_bytes
        $fatal(1, "ahb_lite_rif_bridge: BYTE_COUNT must equal DATA_WIDTH/8");
    end

    localparam int         LOG2_BC  = $clog2(BYTE_COUNT);
    localparam logic [2:0] MAX_SIZE = 3'(LOG2_BC);

    // Counter only has to reach TIMEOUT_CYCLES-1.
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE,
        S_ERR1,
        S_ERR2
    } state_t;

    // Byte lanes covered by an aligned transfer of 2^size bytes at addr.
    function automatic logic [BYTE_COUNT-1:0] lane_strobe(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [2:0]            size
    );
        logic [BYTE_COUNT-1:0] strb;
        int                    off;
        int                    nbytes;
        strb   = '0;
        off    = 0;
        nbytes = 1 << size;
        for (int k = 0; k < LOG2_BC; k++) begin
            if (addr[k]) begin
                off = off + (1 << k);
            end
        end
        for (int i = 0; i < BYTE_COUNT; i++) begin
            strb[i] = (i >= off) && (i < off + nbytes);
        end
        return strb;
    endfunction

    // Expand one strobe bit per lane into a full byte mask.
    function automatic logic [DATA_WIDTH-1:0] lane_mask(
        input logic [BYTE_COUNT-1:0] strb
    );
        logic [DATA_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < BYTE_COUNT; i++) begin
            m[8*i +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

    state_t                state_q,  state_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [2:0]            size_q,   size_d;
    logic                  write_q,  write_d;
    logic                  nonsec_q, nonsec_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;

    logic                  accept;
    logic                  size_bad;
    logic                  misalign;
    logic                  sec_bad;
    logic                  precheck_ok;
    logic [ADDR_WIDTH-1:0] align_mask;
    logic [BYTE_COUNT-1:0] strb;
    logic [DATA_WIDTH-1:0] dmask;

    // Only NONSEQ/SEQ (HTRANS[1]=1) start an access; the latched attribute
    // is kept for debug visibility but the check uses the live HNONSEC.
    logic unused_bits;
    assign unused_bits = ^{HTRANS[0], nonsec_q};

    assign accept      = HSEL & HREADY & HTRANS[1];
    assign size_bad    = (HSIZE > MAX_SIZE);
    assign align_mask  = (ADDR_WIDTH'(1) << HSIZE) - ADDR_WIDTH'(1);
    assign misalign    = |(HADDR & align_mask);
    assign sec_bad     = (SEC_TRANS != 0) && HNONSEC;
    assign precheck_ok = !(size_bad || misalign || sec_bad);

    assign strb  = lane_strobe(addr_q, size_q);
    assign dmask = lane_mask(strb);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        write_d  = write_q;
        nonsec_d = nonsec_q;
        cnt_d    = cnt_q;
        hrdata_d = hrdata_q;
        case (state_q)
            S_ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                if (rif_ready) begin
                    if (rif_err) begin
                        state_d = S_ERR1;
                    end else begin
                        state_d = S_DONE;
                        if (!write_q) begin
                            hrdata_d = rif_rdata & dmask;
                        end
                    end
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    state_d = S_ERR1;
                end
            end
            S_ERR1: begin
                state_d = S_ERR2;
            end
            default: begin
                // IDLE, DONE and ERR2 all present HREADYOUT=1, so a new
                // address phase can be taken here without a gap.
                if (accept) begin
                    addr_d   = HADDR;
                    size_d   = HSIZE;
                    write_d  = HWRITE;
                    nonsec_d = HNONSEC;
                    if (precheck_ok) begin
                        state_d = S_ACCESS;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_ERR1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            write_q  <= 1'b0;
            nonsec_q <= 1'b0;
            cnt_q    <= '0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            write_q  <= write_d;
            nonsec_q <= nonsec_d;
            cnt_q    <= cnt_d;
            hrdata_q <= hrdata_d;
        end
    end

    assign HREADYOUT = (state_q != S_ACCESS) && (state_q != S_ERR1);
    assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign HRDATA    = hrdata_q;

    assign rif_req   = (state_q == S_ACCESS);
    assign rif_write = write_q;
    assign rif_addr  = addr_q;
    assign rif_wstrb = strb;
    // HWDATA is stable for the whole data phase because HREADYOUT is low.
    assign rif_wdata = HWDATA & dmask;

endmodule

// File: tb/tb_ahb_lite_rif_bridge.sv
module tb_ahb_lite_rif_bridge;

    logic        HCLK    = 1'b0;
    logic        HRESET  = 1'b1;
    logic        HSEL    = 1'b0;
    logic [11:0] HADDR   = '0;
    logic [1:0]  HTRANS  = '0;
    logic        HWRITE  = 1'b0;
    logic [2:0]  HSIZE   = '0;
    logic        HNONSEC = 1'b0;
    logic [31:0] HWDATA  = '0;
    logic        HREADY  = 1'b1;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        rif_req;
    logic        rif_write;
    logic [11:0] rif_addr;
    logic [3:0]  rif_wstrb;
    logic [31:0] rif_wdata;
    logic        rif_ready = 1'b0;
    logic        rif_err   = 1'b0;
    logic [31:0] rif_rdata = '0;

    int n_checks = 0;
    int n_errors = 0;
    int waits;
    int req_cycles;

    ahb_lite_rif_bridge #(
        .ADDR_WIDTH    (12),
        .DATA_WIDTH    (32),
        .SEC_TRANS     (1),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .HSEL     (HSEL),
        .HADDR    (HADDR),
        .HTRANS   (HTRANS),
        .HWRITE   (HWRITE),
        .HSIZE    (HSIZE),
        .HNONSEC  (HNONSEC),
        .HWDATA   (HWDATA),
        .HREADY   (HREADY),
        .HREADYOUT(HREADYOUT),
        .HRESP    (HRESP),
        .HRDATA   (HRDATA),
        .rif_req  (rif_req),
        .rif_write(rif_write),
        .rif_addr (rif_addr),
        .rif_wstrb(rif_wstrb),
        .rif_wdata(rif_wdata),
        .rif_ready(rif_ready),
        .rif_err  (rif_err),
        .rif_rdata(rif_rdata)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic mid();
        @(negedge HCLK);
    endtask

    task automatic addr_ph(input logic wr, input logic [11:0] a, input logic [2:0] sz, input logic ns);
        HSEL    = 1'b1;
        HTRANS  = 2'b10;
        HWRITE  = wr;
        HADDR   = a;
        HSIZE   = sz;
        HNONSEC = ns;
    endtask

    task automatic bus_idle();
        HSEL    = 1'b0;
        HTRANS  = 2'b00;
        HNONSEC = 1'b0;
    endtask

    initial begin
        // Reset
        repeat (2) cyc();
        HRESET = 1'b0;
        mid();
        check("rst_hreadyout", HREADYOUT, 1);
        check("rst_hresp", HRESP, 0);
        check("rst_hrdata", HRDATA, 0);
        check("rst_rif_req", rif_req, 0);
        cyc();

        // Word write at 0x014, ready on first ACCESS cycle
        addr_ph(1'b1, 12'h014, 3'd2, 1'b0);
        mid();
        check("t1_idle_ready", HREADYOUT, 1);
        cyc();
        bus_idle();
        HWDATA    = 32'hDEADBEEF;
        rif_ready = 1'b1;
        mid();
        check("t1_req", rif_req, 1);
        check("t1_write", rif_write, 1);
        check("t1_addr", rif_addr, 12'h014);
        check("t1_wstrb", rif_wstrb, 4'hF);
        check("t1_wdata", rif_wdata, 32'hDEADBEEF);
        check("t1_wait", HREADYOUT, 0);
        cyc();
        rif_ready = 1'b0;
        mid();
        check("t1_done_ready", HREADYOUT, 1);
        check("t1_done_resp", HRESP, 0);
        check("t1_done_req", rif_req, 0);
        cyc();

        // Halfword write at 0x016: upper lanes only, lower lanes masked
        addr_ph(1'b1, 12'h016, 3'd1, 1'b0);
        cyc();
        bus_idle();
        HWDATA    = 32'hDEADBEEF;
        rif_ready = 1'b1;
        mid();
        check("hw_wstrb", rif_wstrb, 4'hC);
        check("hw_wdata", rif_wdata, 32'hDEAD0000);
        cyc();
        rif_ready = 1'b0;
        cyc();

        // Byte read at 0x013, ready on third ACCESS cycle
        addr_ph(1'b0, 12'h013, 3'd0, 1'b0);
        cyc();
        bus_idle();
        waits = 0;
        for (int k = 0; k < 3; k++) begin
            rif_ready = (k == 2);
            rif_rdata = 32'h11223344;
            mid();
            if (k == 0) begin
                check("t2_req", rif_req, 1);
                check("t2_wstrb", rif_wstrb, 4'h8);
            end
            if (!HREADYOUT) waits++;
            cyc();
        end
        rif_ready = 1'b0;
        rif_rdata = '0;
        mid();
        check("t2_waits", waits, 3);
        check("t2_done_ready", HREADYOUT, 1);
        check("t2_done_resp", HRESP, 0);
        check("t2_hrdata", HRDATA, 32'h11000000);
        cyc();

        // Misaligned halfword write at 0x001, next transfer taken in ERR2
        addr_ph(1'b1, 12'h001, 3'd1, 1'b0);
        cyc();
        bus_idle();
        mid();
        check("t3_err1_ready", HREADYOUT, 0);
        check("t3_err1_resp", HRESP, 1);
        check("t3_err1_req", rif_req, 0);
        cyc();
        addr_ph(1'b1, 12'h020, 3'd2, 1'b0);
        mid();
        check("t3_err2_ready", HREADYOUT, 1);
        check("t3_err2_resp", HRESP, 1);
        check("t3_err2_req", rif_req, 0);
        cyc();
        bus_idle();
        HWDATA    = 32'hCAFEF00D;
        rif_ready = 1'b1;
        mid();
        check("t3_next_req", rif_req, 1);
        check("t3_next_addr", rif_addr, 12'h020);
        check("t3_next_wdata", rif_wdata, 32'hCAFEF00D);
        cyc();
        rif_ready = 1'b0;
        mid();
        check("t3_next_resp", HRESP, 0);
        cyc();

        // Oversized transfer (doubleword on a 32-bit bus)
        addr_ph(1'b0, 12'h000, 3'd3, 1'b0);
        cyc();
        bus_idle();
        mid();
        check("size_resp", HRESP, 1);
        check("size_req", rif_req, 0);
        cyc();
        cyc();

        // BUSY and HREADY=0 are not accepted
        HSEL   = 1'b1;
        HTRANS = 2'b01;
        cyc();
        mid();
        check("busy_req", rif_req, 0);
        check("busy_ready", HREADYOUT, 1);
        cyc();
        addr_ph(1'b0, 12'h004, 3'd2, 1'b0);
        HREADY = 1'b0;
        cyc();
        mid();
        check("hready0_req", rif_req, 0);
        cyc();
        HREADY = 1'b1;
        bus_idle();
        cyc();

        // Read ending in RIF error on the second ACCESS cycle
        addr_ph(1'b0, 12'h004, 3'd2, 1'b0);
        cyc();
        bus_idle();
        mid();
        check("t4_req", rif_req, 1);
        cyc();
        rif_ready = 1'b1;
        rif_err   = 1'b1;
        rif_rdata = 32'hBAD0BAD0;
        mid();
        check("t4_wait", HREADYOUT, 0);
        cyc();
        rif_ready = 1'b0;
        rif_err   = 1'b0;
        rif_rdata = '0;
        mid();
        check("t4_err1_ready", HREADYOUT, 0);
        check("t4_err1_resp", HRESP, 1);
        check("t4_err1_req", rif_req, 0);
        cyc();
        mid();
        check("t4_err2_ready", HREADYOUT, 1);
        check("t4_err2_resp", HRESP, 1);
        check("t4_hrdata_kept", HRDATA, 32'h11000000);
        cyc();

        // Watchdog: rif_ready never arrives
        addr_ph(1'b0, 12'h008, 3'd2, 1'b0);
        cyc();
        bus_idle();
        req_cycles = 0;
        for (int k = 0; k < 8; k++) begin
            mid();
            if (!rif_req) break;
            req_cycles++;
            cyc();
        end
        check("t5_req_cycles", req_cycles, 4);
        check("t5_err1_resp", HRESP, 1);
        check("t5_err1_ready", HREADYOUT, 0);
        cyc();
        mid();
        check("t5_err2_ready", HREADYOUT, 1);
        check("t5_err2_resp", HRESP, 1);
        cyc();

        // Non-secure access rejected
        addr_ph(1'b0, 12'h00C, 3'd2, 1'b1);
        cyc();
        bus_idle();
        mid();
        check("sec_err1_req", rif_req, 0);
        check("sec_err1_resp", HRESP, 1);
        check("sec_err1_ready", HREADYOUT, 0);
        cyc();
        mid();
        check("sec_err2_req", rif_req, 0);
        check("sec_err2_ready", HREADYOUT, 1);
        cyc();

        // Back-to-back write then read, second address taken in DONE
        addr_ph(1'b1, 12'h030, 3'd2, 1'b0);
        cyc();
        HWDATA    = 32'h12345678;
        rif_ready = 1'b1;
        addr_ph(1'b0, 12'h034, 3'd2, 1'b0);
        mid();
        check("t6_w_addr", rif_addr, 12'h030);
        check("t6_w_write", rif_write, 1);
        cyc();
        rif_ready = 1'b0;
        mid();
        check("t6_done_ready", HREADYOUT, 1);
        check("t6_done_req", rif_req, 0);
        cyc();
        bus_idle();
        rif_ready = 1'b1;
        rif_rdata = 32'hA5A5A5A5;
        mid();
        check("t6_r_req", rif_req, 1);
        check("t6_r_addr", rif_addr, 12'h034);
        check("t6_r_write", rif_write, 0);
        cyc();
        rif_ready = 1'b0;
        rif_rdata = '0;
        mid();
        check("t6_hrdata", HRDATA, 32'hA5A5A5A5);
        cyc();

        // Reset during ACCESS
        addr_ph(1'b0, 12'h038, 3'd2, 1'b0);
        cyc();
        bus_idle();
        mid();
        check("rst_mid_req_before", rif_req, 1);
        HRESET = 1'b1;
        cyc();
        HRESET = 1'b0;
        mid();
        check("rst_mid_ready", HREADYOUT, 1);
        check("rst_mid_resp", HRESP, 0);
        check("rst_mid_hrdata", HRDATA, 0);
        check("rst_mid_req", rif_req, 0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ahb_lite_rif_bridge.md
Name: ahb_lite_rif_bridge

Overview:
- AHB-Lite subordinate to register-interface (RIF) bridge; next-generation adapter in front of the register files.
- Adds over the previous adapter: RIF wait states via `rif_ready`, RIF error forwarding, a timeout watchdog, address-aligned byte strobes, and alignment/size/security pre-checks.
- All pre-check failures end in a proper two-cycle AHB ERROR response; HREADYOUT and HRESP are decoded from state registers only.

Parameters:
- ADDR_WIDTH, 12: HADDR / rif_addr width.
- DATA_WIDTH, 32: data width. Legal values 8, 16, 32, 64, 128, 256, 512, 1024; any other value is a $fatal at elaboration.
- SEC_TRANS, 0: when 1, any transfer with HNONSEC=1 gets an ERROR response and never reaches the RIF.
- TIMEOUT_CYCLES, 16: maximum ACCESS cycles waiting for `rif_ready`. 0 disables the watchdog.
- BYTE_COUNT, DATA_WIDTH/8: strobe width (derived, do not override).

Ports:
- HCLK  in  1  clock
- HRESET  in  1  synchronous, active-high reset
- HSEL  in  1  subordinate select
- HADDR  in  ADDR_WIDTH  address
- HTRANS  in  2  transfer type
- HWRITE  in  1  write/read
- HSIZE  in  3  transfer size
- HNONSEC  in  1  non-secure attribute
- HWDATA  in  DATA_WIDTH  write data
- HREADY  in  1  bus ready (HREADYIN)
- HREADYOUT  out  1  subordinate ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- HRDATA  out  DATA_WIDTH  read data (registered)
- rif_req  out  1  RIF access request
- rif_write  out  1  1 = write
- rif_addr  out  ADDR_WIDTH  latched address
- rif_wstrb  out  BYTE_COUNT  byte-lane strobes
- rif_wdata  out  DATA_WIDTH  masked write data
- rif_ready  in  1  RIF completes access
- rif_err  in  1  RIF error, qualified by rif_ready
- rif_rdata  in  DATA_WIDTH  RIF read data, valid with rif_ready

Behaviour:
- Single clock HCLK. HRESET is sampled on the HCLK edge.
- Reset values: state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, rif_req=0, timeout counter=0, address-phase latches=0.

Transfer acceptance:
- accept = HSEL & HREADY & HTRANS[1], evaluated only in IDLE, DONE or ERR2.
- On accept, latch HADDR, HSIZE, HWRITE, HNONSEC.
- IDLE and BUSY transfers, or HSEL=0, get a zero-wait OKAY and the state returns to IDLE.

Pre-check (on accept), any failure -> ERR1, no RIF access:
- HSIZE > log2(BYTE_COUNT);
- HADDR not aligned to 2^HSIZE;
- SEC_TRANS=1 and HNONSEC=1.

States:
- IDLE: HREADYOUT=1, HRESP=0. Accept with pre-check pass -> ACCESS; accept with pre-check fail -> ERR1.
- ACCESS (data phase): HREADYOUT=0, HRESP=0, rif_req=1, rif_write=latched HWRITE, rif_addr=latched address. Counter increments each cycle.
  - rif_ready & !rif_err -> DONE. On a read, the same edge captures HRDATA from rif_rdata, masked by strobes; unselected lanes are 0.
  - rif_ready & rif_err -> ERR1; HRDATA is not updated.
  - counter reaches TIMEOUT_CYCLES-1 with no rif_ready (TIMEOUT_CYCLES != 0) -> ERR1. rif_req deasserts with the state change.
- DONE: HREADYOUT=1, HRESP=0. Accept -> ACCESS or ERR1 (pipelined back-to-back); else -> IDLE.
- ERR1: HREADYOUT=0, HRESP=1. Always -> ERR2.
- ERR2: HREADYOUT=1, HRESP=1. Accept -> ACCESS or ERR1; else -> IDLE.
- Counter clears on every entry to ACCESS.

Strobes and data:
- rif_wstrb = ((1 << 2^size) - 1) << addr[log2(BYTE_COUNT)-1:0].
- rif_wdata = HWDATA with lanes outside rif_wstrb forced to 0. HWDATA is used directly because it stays stable while HREADYOUT=0.
- rif_wstrb is also driven on reads, as the lane qualifier.
- HRDATA holds its value through writes, errors and idle cycles; only a successful read completion updates it.

Latency and timing:
- Minimum OKAY transfer = one wait state (ACCESS one cycle with rif_ready=1, then DONE).
- rif_ready is ignored outside ACCESS.

Reset mid-operation:
- HRESET asserted in any state -> IDLE at that edge; rif_req=0 from the next cycle.
- An outstanding RIF access is abandoned and no AHB response is generated.

Test Plan:
1. Word write, DATA_WIDTH=32: HADDR=0x014, HWDATA=0xDEADBEEF, rif_ready high on the first ACCESS cycle -> rif_req for 1 cycle, rif_wstrb=0xF, rif_addr=0x014, HREADYOUT low 1 cycle, then OKAY.
2. Byte read at 0x013, rif_rdata=0x11223344, rif_ready after 3 cycles -> 3 wait states, rif_wstrb=0x8, HRDATA=0x11000000, OKAY.
3. Halfword write at 0x001 (misaligned) -> no rif_req; HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1; next transfer accepted in ERR2.
4. Read with rif_ready=1, rif_err=1 on the second ACCESS cycle -> two-cycle ERROR; HRDATA keeps its previous value.
5. TIMEOUT_CYCLES=4, rif_ready held 0 -> rif_req high exactly 4 cycles, then ERROR. SEC_TRANS=1 with HNONSEC=1 -> immediate ERROR with rif_req never asserted.
6. Back-to-back NONSEQ write then read, and HRESET asserted during ACCESS -> second address accepted in DONE with no idle gap. Reset returns IDLE, HREADYOUT=1, HRDATA=0, rif_req=0 on the following cycle.
